// File: rtl/multi_channel_tick_gen.sv
// CHANNELS independent programmable tick generators (periodic / one-shot) with square-wave outputs.
// Retunes of a running channel are held pending until its next period boundary.
module multi_channel_tick_gen #(
  parameter int                CHANNELS    = 4,
  parameter int                WIDTH       = 20,
  parameter logic [WIDTH-1:0]  DEFAULT_DIV = WIDTH'(999),
  localparam int               CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic [1:0]          cfg_mode,
  input  logic                sync_start,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sq,
  output logic [CHANNELS-1:0] busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  logic [WIDTH-1:0]    cnt_q      [CHANNELS];
  logic [WIDTH-1:0]    cnt_d      [CHANNELS];
  logic [WIDTH-1:0]    div_q      [CHANNELS];
  logic [WIDTH-1:0]    div_d      [CHANNELS];
  logic [WIDTH-1:0]    pend_div_q [CHANNELS];
  logic [WIDTH-1:0]    pend_div_d [CHANNELS];
  logic [1:0]          mode_q     [CHANNELS];
  logic [1:0]          mode_d     [CHANNELS];
  logic [1:0]          pend_mode_q[CHANNELS];
  logic [1:0]          pend_mode_d[CHANNELS];
  state_e              state_q    [CHANNELS];
  state_e              state_d    [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] sq_q, sq_d;
  logic [CHANNELS-1:0] wr_hit;
  logic                pend_sel;

  // An out-of-range channel never matches, so such writes are accepted and dropped.
  always_comb begin
    pend_sel = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == CH_W'(i)) pend_sel = pend_q[i];
    end
  end

  assign cfg_ready = !pend_sel;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      tick[i]   = (state_q[i] == RUN) && (cnt_q[i] == div_q[i]);
      busy[i]   = (state_q[i] == RUN);
      wr_hit[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  assign sq = sq_q;

  always_comb begin
    pend_d = pend_q;
    sq_d   = sq_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]       = cnt_q[i];
      div_d[i]       = div_q[i];
      mode_d[i]      = mode_q[i];
      pend_div_d[i]  = pend_div_q[i];
      pend_mode_d[i] = pend_mode_q[i];
      state_d[i]     = state_q[i];
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (wr_hit[i]) begin
            div_d[i]   = cfg_div;
            mode_d[i]  = cfg_mode;
            state_d[i] = cfg_mode[0] ? RUN : IDLE;
          end
        end
        default: begin
          if (tick[i]) begin
            cnt_d[i] = '0;
            sq_d[i]  = ~sq_q[i];
            if (pend_q[i]) begin
              div_d[i]   = pend_div_q[i];
              mode_d[i]  = pend_mode_q[i];
              pend_d[i]  = 1'b0;
              state_d[i] = pend_mode_q[i][0] ? RUN : IDLE;
            end else if (mode_q[i][1] || !mode_q[i][0]) begin
              state_d[i] = IDLE;
              // A write landing on the final one-shot edge is loaded directly, as for an idle channel.
              if (wr_hit[i]) begin
                div_d[i]   = cfg_div;
                mode_d[i]  = cfg_mode;
                state_d[i] = cfg_mode[0] ? RUN : IDLE;
              end
            end
          end else if (sync_start) begin
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + WIDTH'(1);
          end
          if (wr_hit[i] && !(tick[i] && !pend_q[i] && (mode_q[i][1] || !mode_q[i][0]))) begin
            pend_d[i]      = 1'b1;
            pend_div_d[i]  = cfg_div;
            pend_mode_d[i] = cfg_mode;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      sq_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]       <= '0;
        div_q[i]       <= DEFAULT_DIV;
        mode_q[i]      <= 2'b00;
        pend_div_q[i]  <= '0;
        pend_mode_q[i] <= 2'b00;
        state_q[i]     <= IDLE;
      end
    end else begin
      pend_q <= pend_d;
      sq_q   <= sq_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]       <= cnt_d[i];
        div_q[i]       <= div_d[i];
        mode_q[i]      <= mode_d[i];
        pend_div_q[i]  <= pend_div_d[i];
        pend_mode_q[i] <= pend_mode_d[i];
        state_q[i]     <= state_d[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_tick_gen.sv
// Directed bench for multi_channel_tick_gen: predicted ticks go into a queue, a monitor matches DUT ticks.
module tb_multi_channel_tick_gen;

  localparam int CHANNELS = 3;
  localparam int WIDTH    = 20;
  localparam int CH_W     = 2;
  localparam int EW       = 19;  // {cycle[15:0], ch[1:0], sq_before}

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [WIDTH-1:0]    cfg_div;
  logic [1:0]          cfg_mode;
  logic                sync_start;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] sq;
  logic [CHANNELS-1:0] busy;

  logic [EW-1:0] exp_q[$];
  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  multi_channel_tick_gen #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode), .sync_start(sync_start),
    .tick(tick), .sq(sq), .busy(busy)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_tick(input int ch, input int c, input int s);
    exp_q.push_back({c[15:0], ch[1:0], s[0]});
  endtask

  // Monitor: every observed tick must match a predicted (cycle, channel) entry.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (tick[ch]) begin
          automatic int idx = -1;
          automatic logic [EW-2:0] key = {cyc[15:0], 2'(ch)};
          for (int k = 0; k < exp_q.size(); k++)
            if (idx < 0 && exp_q[k][EW-1:1] == key) idx = k;
          n_checks++;
          if (idx < 0) begin
            n_errors++;
            $display("FAIL unexpected_tick: ch %0d tick=1 at cycle %0d, expected tick=0", ch, cyc);
          end else begin
            if (exp_q[idx][0] != sq[ch]) begin
              n_errors++;
              $display("FAIL tick_sq: ch %0d cycle %0d sq=%0b expected %0b", ch, cyc, sq[ch], exp_q[idx][0]);
            end
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic cfg_write(input int ch, input int dv, input int md, output int acc);
    int tries = 0;
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = WIDTH'(dv);
    cfg_mode  = 2'(md);
    #1;
    while (!cfg_ready && tries < 50) begin
      step();
      #1;
      tries++;
    end
    if (!cfg_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL cfg_write_timeout: cfg_ready=0 for ch %0d, expected 1", ch);
    end
    step();
    acc       = cyc;
    cfg_valid = 1'b0;
    #1;
  endtask

  initial begin
    int a0, a1, a2, a3, a4, a5, a6, a, s;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = '0; sync_start = 1'b0;

    // Reset state
    #3;
    check("rst_tick", int'(tick), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sq", int'(sq), 0);
    check("rst_ready", int'(cfg_ready), 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Periodic ch0 div=3, then stop via pending disable
    cfg_write(0, 3, 1, a0);
    push_tick(0, a0 + 3, 0); push_tick(0, a0 + 7, 1); push_tick(0, a0 + 11, 0);
    go_to(a0 + 5);
    check("t1_busy0", int'(busy[0]), 1);
    check("t1_sq0_after1", int'(sq[0]), 1);
    go_to(a0 + 8);
    check("t1_sq0_after2", int'(sq[0]), 0);
    cfg_write(0, 0, 0, a);
    check("t1_acc", a, a0 + 9);
    check("t1_ready_pend", int'(cfg_ready), 0);
    go_to(a0 + 12);
    check("t1_busy0_off", int'(busy[0]), 0);
    check("t1_ready_back", int'(cfg_ready), 1);
    check("t1_sq0_after3", int'(sq[0]), 1);

    // One-shot ch1 div=2
    cfg_write(1, 2, 3, a1);
    push_tick(1, a1 + 2, 0);
    go_to(a1 + 3);
    check("t2_busy1", int'(busy[1]), 0);
    check("t2_sq1", int'(sq[1]), 1);
    go_to(a1 + 23);
    check("t2_busy1_late", int'(busy[1]), 0);
    check("t2_sq1_late", int'(sq[1]), 1);

    // Retune running ch0 div=9 -> 1 at cnt=4
    cfg_write(0, 9, 1, a2);
    push_tick(0, a2 + 9, 1); push_tick(0, a2 + 11, 0);
    push_tick(0, a2 + 13, 1); push_tick(0, a2 + 15, 0);
    go_to(a2 + 4);
    cfg_write(0, 1, 1, a);
    check("t3_acc", a, a2 + 5);
    check("t3_ready_drop", int'(cfg_ready), 0);
    go_to(a2 + 9);
    check("t3_ready_at_tick", int'(cfg_ready), 0);
    go_to(a2 + 10);
    check("t3_ready_back", int'(cfg_ready), 1);
    go_to(a2 + 14);
    cfg_write(0, 0, 0, a);
    go_to(a2 + 16);
    check("t3_busy0_off", int'(busy[0]), 0);
    check("t3_sq0", int'(sq[0]), 1);

    // div=0 on ch2: tick every cycle, then pending stop
    cfg_write(2, 0, 1, a3);
    for (int k = 0; k < 5; k++) push_tick(2, a3 + k, k % 2);
    go_to(a3 + 1);
    check("t4_sq2_c1", int'(sq[2]), 1);
    go_to(a3 + 2);
    check("t4_sq2_c2", int'(sq[2]), 0);
    go_to(a3 + 3);
    cfg_write(2, 0, 0, a);
    go_to(a3 + 5);
    check("t4_busy2_off", int'(busy[2]), 0);
    check("t4_sq2_final", int'(sq[2]), 1);

    // sync_start phase alignment, incl. sync coinciding with tick[0]
    cfg_write(0, 5, 1, a4);
    cfg_write(1, 7, 1, a5);
    check("t5_acc1", a5, a4 + 1);
    s = a4 + 3;
    push_tick(0, s + 6, 1); push_tick(0, s + 12, 0); push_tick(0, s + 18, 1);
    push_tick(1, s + 8, 1); push_tick(1, s + 20, 0);
    go_to(s);
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    go_to(s + 12);
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    cfg_write(0, 0, 0, a);
    cfg_write(1, 0, 0, a);
    go_to(s + 21);
    check("t5_busy_off", int'(busy), 0);
    check("t5_sq0", int'(sq[0]), 0);
    check("t5_sq1", int'(sq[1]), 1);

    // Reset mid-period with a pending write
    cfg_write(2, 9, 1, a6);
    go_to(a6 + 2);
    cfg_write(2, 2, 1, a);
    check("t6_ready_pend", int'(cfg_ready), 0);
    go_to(a6 + 4);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tick", int'(tick), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_sq", int'(sq), 0);
    check("t6_rst_ready", int'(cfg_ready), 1);
    repeat (3) step();
    check("t6_rst_busy_hold", int'(busy), 0);
    #2 rst_n = 1'b1;
    step();
    cfg_ch = 2'd3;
    #1;
    check("t6_ready_oor", int'(cfg_ready), 1);
    cfg_write(3, 1, 1, a);
    go_to(a + 12);
    check("t6_oor_busy", int'(busy), 0);
    check("t6_oor_sq", int'(sq), 0);
    cfg_ch = 2'd2;
    #1;
    check("t6_ready_ch2", int'(cfg_ready), 1);

    // Every predicted tick must have been observed
    step();
    check("exp_q_empty", exp_q.size(), 0);
    foreach (exp_q[k])
      $display("FAIL missed_tick: ch %0d cycle %0d not seen, expected tick=1", exp_q[k][2:1], exp_q[k][18:3]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
